ru_writeback_arbiter: RTL
=========================

// Module: ru_writeback_arbiter
// PURPOSE
// - Shares the single register-file write port (RUWr/rd/DataWR) between two write-back sources: ALU (1-cycle) and MEM (load unit).
// - Keeps a per-register busy scoreboard so decode can stall on RAW hazards against writes not yet committed.
// - Sits between execute/memory stages and RegistersUnit; its ru_* outputs drive RUWr, rd, DataWR directly.
// PARAMETERS
// - XLEN        32  data width of write-back values
// - AW          5   register index width (2**AW registers; x0 hardwired zero)
// - STARVE_MAX  3   consecutive ALU losses before ALU is forced to win; range 1..15
// PORTS
// - clk          in   1     system clock, all state on rising edge
// - rst          in   1     asynchronous, active-high reset
// - issue_valid  in   1     instruction with a destination issued this cycle
// - issue_rd     in   AW    destination of issued instruction
// - alu_valid    in   1     ALU write-back request
// - alu_rd       in   AW    ALU destination
// - alu_data     in   XLEN  ALU result
// - alu_ready    out  1     ALU request accepted this cycle
// - mem_valid    in   1     MEM write-back request
// - mem_rd       in   AW    MEM destination
// - mem_data     in   XLEN  load result
// - mem_ready    out  1     MEM request accepted this cycle
// - rs1, rs2     in   AW    decode source indices for hazard check
// - hazard_rs1   out  1     rs1 has an uncommitted producer
// - hazard_rs2   out  1     rs2 has an uncommitted producer
// - ru_wr        out  1     to RegistersUnit RUWr
// - ru_rd        out  AW    to RegistersUnit rd
// - ru_data      out  XLEN  to RegistersUnit DataWR
// BEHAVIOUR
// - Reset: ru_wr=0, ru_rd=0, ru_data=0, busy=0, starve_cnt=0, FSM=PRIO_MEM. In-flight requests dropped; sources re-present after reset.
// - Handshake: transfer when valid && ready; ready is combinational from arbitration; at most one ready high per cycle.
// - Requester must hold valid/rd/data stable until ready; arbiter never withdraws a grant once given in that cycle.
// - FSM PRIO_MEM: mem_valid -> MEM granted; else alu_valid -> ALU granted.
//   If alu_valid && not granted: starve_cnt++; when starve_cnt reaches STARVE_MAX -> PRIO_ALU next cycle.
//   Any ALU grant clears starve_cnt.
// - FSM PRIO_ALU: alu_valid -> ALU granted, starve_cnt=0, -> PRIO_MEM; if alu_valid dropped -> PRIO_MEM, starve_cnt=0.
// - Output register: granted request appears on ru_rd/ru_data next cycle with ru_wr=1 (latency 1); no grant -> ru_wr=0, ru_rd/ru_data hold.
// - x0: request with rd=0 is accepted (ready=1) but produces ru_wr=0; never sets/clears busy[0]; hazard on rs=0 always 0.
// - Scoreboard busy[2**AW-1:0]: set on issue_valid && issue_rd!=0; cleared on the grant cycle of a request to that rd.
//   Same rd set and cleared in one cycle: set wins (younger producer pending).
//   Set on an already-busy rd: stays busy (single bit, no counting).
// - hazard_rsN = busy[rsN] && rsN!=0, combinational from current busy state.
// CONFIGURATION
// - RU_WB_FORWARD_EN defined: this cycle's granted rd/data bypass the scoreboard; adds outputs fwd_rs1_sel, fwd_rs2_sel (1) and fwd_data (XLEN).
//   fwd_rsN_sel=1 when a grant with rd!=0 matches rsN; hazard_rsN forced 0 in that case; fwd_data = granted data.
// - Not defined: no fwd_* ports; hazard_rsN stays high until the grant cycle has passed (busy cleared).
// TESTING
// - Reset mid-op: busy[5]=1, mem_valid held, assert rst -> ru_wr=0, hazard_rs1(rs1=5)=0, FSM PRIO_MEM, starve_cnt=0.
// - Single ALU: alu_valid, rd=7, data=0x1234 -> alu_ready same cycle; next cycle ru_wr=1, ru_rd=7, ru_data=0x1234.
// - Conflict: alu and mem both valid 4 cycles (STARVE_MAX=3) -> MEM grants cycles 0-2, ALU grant cycle 3, then MEM.
// - Scoreboard: issue rd=3, then rs1=3 -> hazard_rs1=1 until MEM grant rd=3; cycle after grant hazard_rs1=0.
// - Same-cycle set/clear: issue rd=9 with ALU grant rd=9 -> busy[9] stays 1.
// - x0: mem_valid rd=0 data=0xFFFF -> mem_ready=1, ru_wr stays 0; issue rd=0 leaves hazard on rs1=0 at 0.

Source files
------------

// File: rtl/ru_writeback_arbiter.sv
// rtl/ru_writeback_arbiter.sv - register-file write-port arbiter (ALU vs MEM) with busy scoreboard
//
// Purpose: shares the single RegistersUnit write port between the ALU and MEM
// write-back sources. MEM normally has priority. An ALU request that loses
// STARVE_MAX consecutive times is forced to win on the following cycle.
// A per-register busy scoreboard tracks issued but uncommitted destinations
// so decode can stall on RAW hazards.
//
// Optional feature macro: RU_WB_FORWARD_EN
//   When defined, this cycle's granted rd/data bypass the scoreboard. The
//   fwd_rs1_sel, fwd_rs2_sel and fwd_data outputs are added, and a matching
//   hazard is suppressed.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   issue_valid, issue_rd       destination issued this cycle (sets busy)
//   alu_valid/rd/data, alu_ready   ALU write-back request handshake
//   mem_valid/rd/data, mem_ready   MEM write-back request handshake
//   rs1, rs2                    decode source indices
//   hazard_rs1, hazard_rs2      source has an uncommitted producer
//   ru_wr, ru_rd, ru_data       registered write port to RegistersUnit
//   fwd_rs1_sel, fwd_rs2_sel, fwd_data   bypass outputs (RU_WB_FORWARD_EN only)
module ru_writeback_arbiter #(
  parameter int XLEN       = 32,
  parameter int AW         = 5,
  parameter int STARVE_MAX = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            hazard_rs1,
  output logic            hazard_rs2,
`ifdef RU_WB_FORWARD_EN
  output logic            fwd_rs1_sel,
  output logic            fwd_rs2_sel,
  output logic [XLEN-1:0] fwd_data,
`endif
  output logic            ru_wr,
  output logic [AW-1:0]   ru_rd,
  output logic [XLEN-1:0] ru_data
);

  localparam int NREG = 1 << AW;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic {PRIO_MEM, PRIO_ALU} state_t;

  state_t            state, state_nxt;
  logic [3:0]        starve_cnt, starve_nxt;
  logic [NREG-1:0]   busy, busy_nxt;
  logic              gnt_alu, gnt_mem;
  logic [AW-1:0]     gnt_rd;
  logic [XLEN-1:0]   gnt_data;
  logic              wr_en;

  // Arbitration and starvation tracking.
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    gnt_alu    = 1'b0;
    gnt_mem    = 1'b0;
    case (state)
      PRIO_MEM: begin
        if (mem_valid)      gnt_mem = 1'b1;
        else if (alu_valid) gnt_alu = 1'b1;
        if (gnt_alu) begin
          starve_nxt = '0;
        end else if (alu_valid) begin
          starve_nxt = starve_cnt + 4'd1;
          if (starve_cnt + 4'd1 >= STARVE_LIM) state_nxt = PRIO_ALU;
        end
      end
      PRIO_ALU: begin
        // One forced ALU slot; if ALU vanished, MEM may use the port.
        starve_nxt = '0;
        state_nxt  = PRIO_MEM;
        if (alu_valid)      gnt_alu = 1'b1;
        else if (mem_valid) gnt_mem = 1'b1;
      end
      default: state_nxt = PRIO_MEM;
    endcase
  end

  assign alu_ready = gnt_alu;
  assign mem_ready = gnt_mem;
  assign gnt_rd    = gnt_alu ? alu_rd   : mem_rd;
  assign gnt_data  = gnt_alu ? alu_data : mem_data;
  // x0 writes are accepted but never reach the register file.
  assign wr_en     = (gnt_alu || gnt_mem) && (gnt_rd != '0);

  // Clear before set so a younger producer of the same rd keeps it busy.
  always_comb begin
    busy_nxt = busy;
    if (wr_en) busy_nxt[gnt_rd] = 1'b0;
    if (issue_valid && (issue_rd != '0)) busy_nxt[issue_rd] = 1'b1;
  end

`ifdef RU_WB_FORWARD_EN
  assign fwd_rs1_sel = wr_en && (gnt_rd == rs1);
  assign fwd_rs2_sel = wr_en && (gnt_rd == rs2);
  assign fwd_data    = gnt_data;
  assign hazard_rs1  = busy[rs1] && (rs1 != '0) && !fwd_rs1_sel;
  assign hazard_rs2  = busy[rs2] && (rs2 != '0) && !fwd_rs2_sel;
`else
  assign hazard_rs1  = busy[rs1] && (rs1 != '0);
  assign hazard_rs2  = busy[rs2] && (rs2 != '0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= PRIO_MEM;
      starve_cnt <= '0;
      busy       <= '0;
      ru_wr      <= 1'b0;
      ru_rd      <= '0;
      ru_data    <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      busy       <= busy_nxt;
      ru_wr      <= wr_en;
      if (wr_en) begin
        ru_rd   <= gnt_rd;
        ru_data <= gnt_data;
      end
    end
  end

endmodule
